mem_stream_reader: RTL and testbench

Sequencing read-side engine for the team's dual-port RAM (`Mem`). On a start command it walks a contiguous, wrapping address range through the RAM's combinational read port. It streams the words out on a valid/ready interface with full backpressure at one word per cycle. It is the read-end counterpart to the producers that fill the RAM through its write port.

---
 rtl/mem_stream_pkg.sv | 20 ++
 rtl/stream_out_reg.sv | 36 +++
 rtl/mem_stream_reader.sv | 145 ++++++++++++++
 tb/tb_mem_stream_reader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stream_pkg.sv
// Shared definitions for the RAM read-stream engine: default widths,
// controller state encoding and the burst-length clamp.
package mem_stream_pkg;

    localparam int DEF_D_WIDTH = 64;
    localparam int DEF_A_WIDTH = 7;
    localparam int DEF_A_MAX   = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A request longer than the RAM would revisit words, so cap it at one full pass.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned a_max);
        return (len > a_max) ? a_max : len;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Valid/ready output register. A load captures a new word and raises valid.
// A clear drops valid once the final word has been taken. Data is otherwise
// held, so a stalled word never changes underneath the consumer.
module stream_out_reg
    import mem_stream_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic [D_WIDTH-1:0] d_in,
    input  logic               last_in,
    output logic [D_WIDTH-1:0] out_data,
    output logic               out_valid,
    output logic               out_last
);

    // Output word register; load takes priority over clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_data  <= d_in;
            out_valid <= 1'b1;
            out_last  <= last_in;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stream_reader.sv
// Read-side burst engine for the dual-port RAM. It walks a wrapping address
// range through the combinational read port and streams the words out over
// valid/ready at up to one word per cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; mem_addr follows base_addr
//   ST_RUN  | output register holds a word; remaining words not yet taken
//   ST_DONE | one-cycle done pulse after the final handshake
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int A_MAX   = DEF_A_MAX
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [A_WIDTH-1:0] base_addr,
    input  logic [A_WIDTH:0]   length,
    output logic               busy,
    output logic               done,
    output logic [A_WIDTH-1:0] mem_addr,
    input  logic [D_WIDTH-1:0] mem_q,
    output logic [D_WIDTH-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last
);

    localparam int LEN_W = A_WIDTH + 1;

    state_t             state_q;
    state_t             state_d;
    logic [A_WIDTH-1:0] addr_q;
    logic [LEN_W-1:0]   remaining_q;
    logic [LEN_W-1:0]   len_clamped;
    logic               hs;
    logic               last_word;
    logic               load;
    logic               clear;
    logic               load_last;

    function automatic logic [A_WIDTH-1:0] next_addr(input logic [A_WIDTH-1:0] a);
        return (a == A_WIDTH'(A_MAX - 1)) ? '0 : a + A_WIDTH'(1);
    endfunction

    assign len_clamped = LEN_W'(clamp_len(32'(length), unsigned'(A_MAX)));
    assign hs          = out_valid & out_ready;
    assign last_word   = (remaining_q == LEN_W'(1));

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (len_clamped == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (hs && last_word) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs and output-register controls derived from the current state.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        mem_addr  = (state_q == ST_IDLE) ? base_addr : addr_q;
        load      = 1'b0;
        clear     = 1'b0;
        load_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (len_clamped != '0)) begin
                    load      = 1'b1;
                    load_last = (len_clamped == LEN_W'(1));
                end
            end
            ST_RUN: begin
                if (hs) begin
                    if (last_word) begin
                        clear = 1'b1;
                    end else begin
                        load      = 1'b1;
                        load_last = (remaining_q == LEN_W'(2));
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Address of the next word to load and count of words not yet handshaken.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q      <= '0;
            remaining_q <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            addr_q      <= next_addr(base_addr);
            remaining_q <= len_clamped;
        end else if ((state_q == ST_RUN) && hs) begin
            remaining_q <= remaining_q - LEN_W'(1);
            if (!last_word) begin
                addr_q <= next_addr(addr_q);
            end
        end
    end

    stream_out_reg #(
        .D_WIDTH (D_WIDTH)
    ) u_out_reg (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .clear     (clear),
        .d_in      (mem_q),
        .last_in   (load_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader with a behavioural RAM model whose
// read port is combinational in mem_addr.
module tb_mem_stream_reader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [6:0]  base_addr;
    logic [7:0]  length;
    logic        busy;
    logic        done;
    logic [6:0]  mem_addr;
    logic [63:0] mem_q;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    logic [63:0] ram [0:127];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [6:0]  base;
        logic [7:0]  len;
        int          exp_n;
        logic [63:0] exp_first;
        int          inject;
    } vec_t;

    vec_t vecs [6];

    assign mem_q = ram[mem_addr];

    mem_stream_reader dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_q     (mem_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue a burst with out_ready high and check every word, out_last, the
    // done timing and busy. Optionally pulse a second start mid-burst.
    task automatic run_burst(input vec_t v, input string tag);
        int         cnt;
        bit         seen_done;
        logic [6:0] a;
        cnt       = 0;
        seen_done = 0;
        out_ready = 1'b1;
        start     = 1'b1;
        base_addr = v.base;
        length    = v.len;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
            if (cyc == v.inject) begin
                start     = 1'b1;
                base_addr = 7'd40;
                length    = 8'd5;
            end else begin
                start = 1'b0;
            end
            check({tag, " busy"}, busy, 1);
            if (done) begin
                seen_done = 1;
                check({tag, " word count"}, cnt, v.exp_n);
                check({tag, " done cycle"}, cyc, v.exp_n);
                check({tag, " valid at done"}, out_valid, 0);
            end else begin
                check({tag, " valid"}, out_valid, 1);
                if (out_valid) begin
                    a = 7'(v.base + 7'(cnt));
                    check({tag, " data"}, out_data, 64'h100 + 64'(a));
                    check({tag, " last"}, out_last, (cnt == v.exp_n - 1) ? 1 : 0);
                    if (cnt == 0) begin
                        check({tag, " first word"}, out_data, v.exp_first);
                    end
                    cnt++;
                end
            end
            step();
        end
        start = 1'b0;
        if (!seen_done) begin
            check({tag, " timeout waiting for done"}, 0, 1);
        end
        check({tag, " busy after done"}, busy, 0);
        check({tag, " done width"}, done, 0);
    endtask

    initial begin
        logic [5:0]  pat;
        logic [63:0] prev_data;
        logic [6:0]  prev_addr;
        bit          prev_stall;
        int          hs;

        for (int i = 0; i < 128; i++) begin
            ram[i] = 64'h100 + 64'(i);
        end

        vecs[0] = '{base: 7'd5,   len: 8'd4,   exp_n: 4,   exp_first: 64'h105, inject: -1};
        vecs[1] = '{base: 7'd126, len: 8'd4,   exp_n: 4,   exp_first: 64'h17E, inject: -1};
        vecs[2] = '{base: 7'd0,   len: 8'd0,   exp_n: 0,   exp_first: 64'h0,   inject: -1};
        vecs[3] = '{base: 7'd0,   len: 8'd200, exp_n: 128, exp_first: 64'h100, inject: -1};
        vecs[4] = '{base: 7'd20,  len: 8'd6,   exp_n: 6,   exp_first: 64'h114, inject: 2};
        vecs[5] = '{base: 7'd127, len: 8'd1,   exp_n: 1,   exp_first: 64'h17F, inject: -1};

        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b0;
        repeat (2) step();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset valid", out_valid, 0);
        check("reset last", out_last, 0);
        check("reset data", out_data, 0);
        check("reset mem_addr", mem_addr, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run_burst(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: ready pattern 0,0,1,0,1,1 over a 3-word burst.
        pat       = 6'b110100;
        out_ready = 1'b0;
        start     = 1'b1;
        base_addr = 7'd0;
        length    = 8'd3;
        step();
        start = 1'b0;
        check("bp first mem_addr", mem_addr, 1);
        hs         = 0;
        prev_stall = 0;
        prev_data  = '0;
        prev_addr  = '0;
        for (int i = 0; i < 6; i++) begin
            out_ready = pat[i];
            check("bp valid", out_valid, 1);
            if (prev_stall) begin
                check("bp stall data", out_data, prev_data);
                check("bp stall mem_addr", mem_addr, prev_addr);
            end
            if (pat[i]) begin
                check("bp hs data", out_data, 64'h100 + 64'(hs));
                check("bp hs last", out_last, (hs == 2) ? 1 : 0);
                hs++;
            end
            prev_data  = out_data;
            prev_addr  = mem_addr;
            prev_stall = !pat[i];
            step();
        end
        check("bp handshakes", hs, 3);
        check("bp done", done, 1);
        check("bp valid after", out_valid, 0);
        out_ready = 1'b1;
        step();

        // A write to a loaded address must not disturb the stalled word, while
        // a word not yet loaded picks up the RAM contents at its load edge.
        out_ready = 1'b0;
        start     = 1'b1;
        base_addr = 7'd50;
        length    = 8'd2;
        step();
        start = 1'b0;
        check("stale first", out_data, 64'h132);
        ram[50] = 64'hDEAD;
        #1;
        check("stale hold", out_data, 64'h132);
        ram[51]   = 64'hBEEF;
        out_ready = 1'b1;
        step();
        check("fresh load", out_data, 64'hBEEF);
        check("fresh last", out_last, 1);
        step();
        check("stale done", done, 1);
        ram[50] = 64'h132;
        ram[51] = 64'h133;
        step();

        // Reset mid-burst abandons it silently.
        out_ready = 1'b1;
        start     = 1'b1;
        base_addr = 7'd0;
        length    = 8'd10;
        step();
        start = 1'b0;
        repeat (2) step();
        check("mid valid", out_valid, 1);
        reset = 1'b1;
        step();
        check("mid rst valid", out_valid, 0);
        check("mid rst last", out_last, 0);
        check("mid rst busy", busy, 0);
        check("mid rst done", done, 0);
        check("mid rst data", out_data, 0);
        check("mid rst mem_addr", mem_addr, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post rst no done", done, 0);
            check("post rst no valid", out_valid, 0);
        end
        run_burst('{base: 7'd10, len: 8'd2, exp_n: 2, exp_first: 64'h10A, inject: -1}, "restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
